// File: rtl/at24c04_pkg.sv
// Shared definitions for the AT24C04-class I2C EEPROM slave.
package at24c04_pkg;

  // Word address width (512 bytes) and byte width.
  localparam int ADDR_W = 9;
  localparam int BYTE_W = 8;

  // Fixed device-type nibble in the device-select byte.
  localparam logic [3:0] DEV_TYPE = 4'b1010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVSEL,
    ST_ACK_DEV,
    ST_WADDR,
    ST_ACK_WADDR,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/at24c04_eeprom_i2c_line_sync.sv
// Synchronizes the SCL/SDA pads into clk_i and derives SCL edge strobes
// plus START/STOP conditions. Strobes are single-cycle and combinational
// from the synchronized and delayed copies.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0] metastability stage, [1] synchronized, [2] one-cycle delayed copy.
  logic [2:0] r_scl_sh;
  logic [2:0] r_sda_sh;

  logic w_scl;
  logic w_scl_d;
  logic w_sda;
  logic w_sda_d;

  // Shift both lines through the synchronizer chain; idle bus reads high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sh <= 3'b111;
      r_sda_sh <= 3'b111;
    end else begin
      r_scl_sh <= {r_scl_sh[1:0], i_scl};
      r_sda_sh <= {r_sda_sh[1:0], i_sda};
    end
  end

  assign w_scl   = r_scl_sh[1];
  assign w_scl_d = r_scl_sh[2];
  assign w_sda   = r_sda_sh[1];
  assign w_sda_d = r_sda_sh[2];

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~w_scl_d;
  assign o_scl_fall = ~w_scl & w_scl_d;
  // SDA may only change while SCL is held high for START/STOP.
  assign o_start    = w_scl & w_scl_d & w_sda_d & ~w_sda;
  assign o_stop     = w_scl & w_scl_d & ~w_sda_d & w_sda;

endmodule

// File: rtl/at24c04_eeprom.sv
// AT24C04-class 512x8 I2C EEPROM slave: device select, byte/page writes
// with page wrap, current/random/sequential reads, WP write inhibit.
// Bus handshake: every byte is sampled on SCL rising edges, the 9th clock
// carries the ACK; SDA is only changed after a detected SCL falling edge.
module at24c04_eeprom
  import at24c04_pkg::*;
#(
  parameter int         MEM_BYTES  = 512,
  parameter int         PAGE_BYTES = 16,
  parameter logic [1:0] A2A1       = 2'b00
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o,
  input  logic wp_i
);

  localparam int LP_PAGE_W = $clog2(PAGE_BYTES);

  logic w_sda;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_stop;

  i2c_line_sync u_sync (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // Erased EEPROM content; the array is deliberately not touched by reset.
  logic [BYTE_W-1:0] r_mem [MEM_BYTES] = '{default: 8'hFF};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic              r_oe;
  logic              w_oe_nxt;
  logic              r_rw;
  logic              w_rw_nxt;
  logic              w_mem_we;
  logic [BYTE_W-1:0] w_byte;
  logic [BYTE_W-1:0] w_rdata;

  // Byte as it stands once the bit on the current rising edge is included.
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_rdata = r_mem[r_addr];

  // Next-state, address, shifter and SDA drive decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_oe_nxt    = r_oe;
    w_rw_nxt    = r_rw;
    w_mem_we    = 1'b0;
    if (w_start) begin
      w_state_nxt = ST_DEVSEL;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_DEVSEL: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = 4'd0;
              if (w_byte[7:4] == DEV_TYPE && w_byte[3:2] == A2A1) begin
                w_state_nxt = ST_ACK_DEV;
                w_rw_nxt    = w_byte[0];
                // P0 only selects the block on writes; reads keep addr[8].
                if (!w_byte[0]) w_addr_nxt[8] = w_byte[1];
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end
          end
        end
        // ACK states: first falling edge (8th) pulls SDA low, the next
        // falling edge (9th) releases it and moves on.
        ST_ACK_DEV, ST_ACK_WADDR, ST_ACK_WDATA: begin
          if (w_fall) begin
            if (!r_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt  = 1'b0;
              w_cnt_nxt = 4'd0;
              if (r_state == ST_ACK_DEV && r_rw) begin
                w_state_nxt = ST_RDATA;
                w_shift_nxt = {w_rdata[6:0], 1'b0};
                w_oe_nxt    = ~w_rdata[7];
                w_addr_nxt  = r_addr + 9'd1;
              end else if (r_state == ST_ACK_DEV) begin
                w_state_nxt = ST_WADDR;
              end else begin
                w_state_nxt = ST_WDATA;
              end
            end
          end
        end
        ST_WADDR: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt        = 4'd0;
              w_addr_nxt[7:0]  = w_byte;
              w_state_nxt      = ST_ACK_WADDR;
            end
          end
        end
        ST_WDATA: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = 4'd0;
              w_mem_we    = ~wp_i;
              w_state_nxt = ST_ACK_WDATA;
              // Page write wraps inside the page; upper bits stay fixed.
              w_addr_nxt[LP_PAGE_W-1:0] = r_addr[LP_PAGE_W-1:0]
                                          + {{(LP_PAGE_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_RDATA: begin
          if (w_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_RACK;
            end else begin
              w_oe_nxt    = ~r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
        ST_RACK: begin
          if (w_rise) begin
            if (w_sda) w_state_nxt = ST_IGNORE;
            else       w_cnt_nxt   = 4'd1;
          end else if (w_fall && r_cnt == 4'd1) begin
            w_state_nxt = ST_RDATA;
            w_cnt_nxt   = 4'd0;
            w_shift_nxt = {w_rdata[6:0], 1'b0};
            w_oe_nxt    = ~w_rdata[7];
            w_addr_nxt  = r_addr + 9'd1;
          end
        end
        default: begin
          w_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // Register FSM state and datapath; reset releases SDA immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= 4'd0;
      r_shift <= '0;
      r_oe    <= 1'b0;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_oe    <= w_oe_nxt;
      r_rw    <= w_rw_nxt;
    end
  end

  // Array write on the cycle the 8th data bit is sampled.
  always_ff @(posedge clk_i) begin
    if (w_mem_we && !rst_i) r_mem[r_addr] <= w_byte;
  end

  assign sda_oe_o = r_oe;

endmodule

// File: tb/tb_at24c04_eeprom.sv
// Directed I2C master bench for at24c04_eeprom.
module tb_at24c04_eeprom;

  logic clk = 1'b0;
  logic rst;
  logic scl_m;
  logic sda_m;
  logic wp;
  logic sda_oe;
  logic sda_line;

  int n_tests = 0;
  int n_fail  = 0;

  // Open-drain bus: line is low if either side pulls it low.
  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  at24c04_eeprom dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe_o (sda_oe),
    .wp_i     (wp)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One SCL clock: data set mid-low, line sampled mid-high.
  task automatic clk_bit(input logic b, output logic seen);
    wait_clk(6);
    sda_m = b;
    wait_clk(6);
    scl_m = 1'b1;
    wait_clk(4);
    seen = sda_line;
    wait_clk(4);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(6);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b0;
    wait_clk(8);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(6);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
  endtask

  // Send a byte and compare the slave's 9th-clock response (1 = ACK).
  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    check(tag, {7'd0, ~s}, {7'd0, exp_ack});
  endtask

  // Receive a byte; mack=1 answers with ACK, 0 with NACK.
  task automatic recv(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  // Random read of one byte with master NACK.
  task automatic rnd_read(input logic [8:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    i2c_start();
    send({4'hA, 2'b00, a[8], 1'b0}, 1'b1, {tag, "_dev"});
    send(a[7:0], 1'b1, {tag, "_addr"});
    i2c_start();
    send(8'hA1, 1'b1, {tag, "_rdev"});
    recv(1'b0, d);
    check(tag, d, exp);
    i2c_stop();
  endtask

  initial begin
    logic [7:0] d;
    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wp    = 1'b0;
    wait_clk(5);
    check("reset_oe", {7'd0, sda_oe}, 8'h00);
    rst = 1'b0;
    wait_clk(5);

    // Byte write then random read back.
    i2c_start();
    send(8'hA0, 1'b1, "t1_dev");
    send(8'h05, 1'b1, "t1_addr");
    send(8'h3C, 1'b1, "t1_data");
    i2c_stop();
    rnd_read(9'h005, 8'h3C, "t1_rd");

    // Page write crossing the page end wraps to 0x00.
    i2c_start();
    send(8'hA0, 1'b1, "t2_dev");
    send(8'h0E, 1'b1, "t2_addr");
    send(8'h11, 1'b1, "t2_d0");
    send(8'h22, 1'b1, "t2_d1");
    send(8'h33, 1'b1, "t2_d2");
    send(8'h44, 1'b1, "t2_d3");
    i2c_stop();
    rnd_read(9'h00E, 8'h11, "t2_rd0e");
    rnd_read(9'h00F, 8'h22, "t2_rd0f");
    rnd_read(9'h000, 8'h33, "t2_rd00");
    rnd_read(9'h001, 8'h44, "t2_rd01");
    rnd_read(9'h010, 8'hFF, "t2_rd10");

    // Top address via P0, then sequential read wrapping 0x1FF -> 0x000.
    i2c_start();
    send(8'hA2, 1'b1, "t3_dev");
    send(8'hFF, 1'b1, "t3_addr");
    send(8'h5A, 1'b1, "t3_data");
    i2c_stop();
    i2c_start();
    send(8'hA2, 1'b1, "t3_dev2");
    send(8'hFF, 1'b1, "t3_addr2");
    i2c_start();
    send(8'hA1, 1'b1, "t3_rdev");
    recv(1'b1, d);
    check("t3_rd1ff", d, 8'h5A);
    recv(1'b0, d);
    check("t3_rd000", d, 8'h33);
    i2c_stop();

    // Write protect: bytes still ACKed, array unchanged.
    wp = 1'b1;
    i2c_start();
    send(8'hA0, 1'b1, "t4_dev");
    send(8'h20, 1'b1, "t4_addr");
    send(8'h77, 1'b1, "t4_data");
    i2c_stop();
    wp = 1'b0;
    rnd_read(9'h020, 8'hFF, "t4_rd20");

    // Non-matching device selects are NACKed and the bus is ignored.
    i2c_start();
    send(8'hB0, 1'b0, "t5_b0");
    send(8'h00, 1'b0, "t5_b0_ign");
    i2c_stop();
    i2c_start();
    send(8'hA4, 1'b0, "t5_a4");
    send(8'h55, 1'b0, "t5_a4_ign");
    i2c_stop();

    // Reset in the middle of a read releases SDA on the next cycle.
    i2c_start();
    send(8'hA0, 1'b1, "t6_dev");
    send(8'h0E, 1'b1, "t6_addr");
    i2c_start();
    send(8'hA1, 1'b1, "t6_rdev");
    wait_clk(6);
    check("t6_oe_drive", {7'd0, sda_oe}, 8'h01);
    rst = 1'b1;
    wait_clk(1);
    check("t6_oe_rst", {7'd0, sda_oe}, 8'h00);
    rst = 1'b0;
    i2c_stop();
    // Current-address read after reset starts at address 0.
    i2c_start();
    send(8'hA1, 1'b1, "t6_cdev");
    recv(1'b0, d);
    check("t6_rd000", d, 8'h33);
    i2c_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
